nibble_pack_fifo: RTL and testbench
===================================

// Module: nibble_pack_fifo
// PURPOSE
//  Input stage of the accelerator datapath, directly downstream of the bench/stimulus
//  driver. It accepts a narrow sample stream (one DW-bit value per valid/ready beat) and
//  packs PACK consecutive samples into one wide word. Packed words are buffered in a
//  DEPTH-entry FIFO and handed to the compute core over a valid/ready output port.
//  i_last flushes a partially filled word early.
// PARAMETERS
//  DW     4  width of one input sample (bits)
//  PACK   4  samples per packed word; output width = DW*PACK
//  DEPTH  4  FIFO entries (power of two, >=2)
// PORTS
//  clk      in   1                    clock; all logic on posedge
//  rst      in   1                    synchronous, active-low reset
//  i_valid  in   1                    input sample valid
//  i_ready  out  1                    input stage can accept a sample
//  i_data   in   DW                   input sample
//  i_last   in   1                    with the accepted beat: close the current word now
//  o_valid  out  1                    FIFO head holds a packed word
//  o_ready  in   1                    consumer takes the head word
//  o_data   out  DW*PACK              head word; lane k at bits [k*DW +: DW]
//  o_lanes  out  $clog2(PACK+1)       number of valid lanes in o_data (1..PACK)
//  o_level  out  $clog2(DEPTH+1)      FIFO occupancy
// BEHAVIOUR
//  - Reset (rst==0 at posedge): lane counter=0, accumulator=0, FIFO empty, o_valid=0,
//    o_data=0, o_lanes=0, o_level=0, i_ready=1. Reset wins over every other event, including
//    a partial word in progress; that word is discarded.
//  - Accept rule: a sample is taken when i_valid && i_ready.
//    i_ready = (o_level != DEPTH), registered from the occupancy with no pop-through.
//  - i_data/i_last are don't-care (X allowed) while i_valid==0. X on them must not
//    corrupt any state.
//  - Packing: an accepted sample goes into lane 'lane_cnt'; lane_cnt then increments.
//  - The word closes when the sample fills lane PACK-1, or when i_last=1 on the accepted beat.
//  - On close, the word is pushed into the FIFO in the same cycle with lanes=lane_cnt+1.
//    Unfilled lanes read as 0, and lane_cnt returns to 0.
//  - Latency: the closed word appears at the FIFO head on the next cycle if the FIFO was empty.
//  - Output: o_valid = (o_level != 0). The word is popped when o_valid && o_ready.
//    o_data/o_lanes hold steady while o_valid && !o_ready.
//  - Empty FIFO: o_data=0 and o_lanes=0.
//  - Same-cycle push and pop: occupancy is unchanged and the pointers both advance,
//    wrapping modulo DEPTH.
//  - Full: i_ready=0, so no push can occur, including the beat that would close a word.
//    A pop while full raises i_ready on the following cycle.
//  - An accepted non-closing sample while FIFO is full is impossible (i_ready=0).
//  - Pop with o_valid==0 is ignored.
//  - The FIFO never overflows or underflows. o_level always equals pushes minus pops since reset.
// TESTING
//  1 rst=0 for 2 cycles, then 1 -> o_valid=0, i_ready=1, o_level=0, o_data=0.
//  2 o_ready=1; drive 0,1,...,7 on consecutive cycles -> o_data 16'h3210 (lanes=4) one cycle
//    after sample 3 is accepted, then 16'h7654; o_level never exceeds 1.
//  3 o_ready=0; stream 16 samples 0..F -> o_level reaches 4, i_ready=0 on the following cycle,
//    and a 17th sample is not accepted. Set o_ready=1 -> words 3210, 7654, BA98, FEDC in order.
//  4 Drive A, then B with i_last=1 -> o_data=16'h00BA, o_lanes=2. The next sample starts in lane 0.
//  5 Occupancy 3, push and pop in the same cycle -> o_level stays 3 and data order is preserved
//    across pointer wrap.
//  6 Accept 2 samples, then rst=0 for one cycle -> FIFO empty. Next 4 samples 1,2,3,4
//    -> 16'h4321 (no stale lanes).

Source files
------------

// File: rtl/nibble_pack_fifo.sv
// nibble_pack_fifo: packs PACK narrow samples into one wide word and buffers
// the packed words in a DEPTH-entry FIFO behind a valid/ready output port.
module nibble_pack_fifo #(
    parameter int unsigned DW    = 4,
    parameter int unsigned PACK  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DW*PACK-1:0]         o_data,
    output logic [$clog2(PACK+1)-1:0]  o_lanes,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int unsigned OW = DW * PACK;
    localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned NW = $clog2(PACK + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [CW-1:0] lane_cnt_q, lane_cnt_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] mem_q [DEPTH];
    logic [OW-1:0] mem_d [DEPTH];
    logic [NW-1:0] lanes_mem_q [DEPTH];
    logic [NW-1:0] lanes_mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          i_ready_q, i_ready_d;
    logic          o_valid_q, o_valid_d;
    logic [OW-1:0] o_data_q, o_data_d;
    logic [NW-1:0] o_lanes_q, o_lanes_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [OW-1:0] word;

    // Packing, FIFO bookkeeping and registered head/handshake outputs.
    always_comb begin
        lane_cnt_d  = lane_cnt_q;
        acc_d       = acc_q;
        mem_d       = mem_q;
        lanes_mem_d = lanes_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        word        = acc_q;

        accept = i_valid && i_ready_q;
        pop    = o_valid_q && o_ready;

        // Current accumulator with the incoming sample dropped into its lane.
        for (int unsigned k = 0; k < PACK; k++) begin
            if (CW'(k) == lane_cnt_q) begin
                word[k*DW +: DW] = i_data;
            end
        end

        push = accept && ((lane_cnt_q == CW'(PACK - 1)) || i_last);

        if (accept) begin
            if (push) begin
                mem_d[wr_ptr_q]       = word;
                lanes_mem_d[wr_ptr_q] = NW'(lane_cnt_q) + NW'(1);
                wr_ptr_d              = wr_ptr_q + PW'(1);
                lane_cnt_d            = '0;
                acc_d                 = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + CW'(1);
                acc_d      = word;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        i_ready_d = (level_d != LW'(DEPTH));
        o_valid_d = (level_d != '0);
        o_data_d  = o_valid_d ? mem_d[rd_ptr_d] : '0;
        o_lanes_d = o_valid_d ? lanes_mem_d[rd_ptr_d] : '0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_cnt_q <= '0;
            acc_q      <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k]       <= '0;
                lanes_mem_q[k] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_lanes_q <= '0;
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            acc_q       <= acc_d;
            mem_q       <= mem_d;
            lanes_mem_q <= lanes_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            i_ready_q   <= i_ready_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_lanes_q   <= o_lanes_d;
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_lanes = o_lanes_q;
    assign o_level = level_q;

endmodule

// File: tb/tb_nibble_pack_fifo.sv
// Directed bench for nibble_pack_fifo with a packing model feeding a scoreboard queue.
module tb_nibble_pack_fifo;

    localparam int unsigned DW    = 4;
    localparam int unsigned PACK  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OW    = DW * PACK;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          i_last;
    logic          o_valid;
    logic          o_ready;
    logic [OW-1:0] o_data;
    logic [2:0]    o_lanes;
    logic [2:0]    o_level;

    nibble_pack_fifo #(.DW(DW), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_lanes (o_lanes),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [18:0] exp_q[$];     // {lanes, data}
    int          m_lane;
    logic [OW-1:0] m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks outputs against the model, applies this cycle's handshakes to it, then clocks.
    task automatic tick();
        bit m_ready;
        bit m_valid;
        if (rst) begin
            m_ready = (exp_q.size() != DEPTH);
            m_valid = (exp_q.size() != 0);
            check("i_ready", 32'(i_ready), 32'(m_ready));
            check("o_valid", 32'(o_valid), 32'(m_valid));
            check("o_level", 32'(o_level), 32'(exp_q.size()));
            if (m_valid) begin
                check("head_data", 32'(o_data), 32'(exp_q[0][15:0]));
                check("head_lanes", 32'(o_lanes), 32'(exp_q[0][18:16]));
                if (o_ready) void'(exp_q.pop_front());
            end else begin
                check("empty_data", 32'(o_data), 32'h0);
                check("empty_lanes", 32'(o_lanes), 32'h0);
            end
            if (i_valid && m_ready) begin
                m_acc[m_lane*DW +: DW] = i_data;
                if (m_lane == PACK - 1 || i_last) begin
                    exp_q.push_back({3'(m_lane + 1), m_acc});
                    m_acc  = '0;
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
        end else begin
            exp_q.delete();
            m_acc  = '0;
            m_lane = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        tick();
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_data  = 'x;
        i_last  = 1'bx;
    endtask

    task automatic drain();
        idle();
        o_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        tick();
        check("drained_level", 32'(o_level), 32'h0);
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b0;
        o_ready = 1'b0;
        m_lane  = 0;
        m_acc   = '0;
        idle();

        // 1: reset
        tick();
        tick();
        rst = 1'b1;
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_i_ready", 32'(i_ready), 32'h1);
        check("rst_o_level", 32'(o_level), 32'h0);
        check("rst_o_data", 32'(o_data), 32'h0);
        tick();

        // 2: streaming with consumer always ready
        o_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            send(4'(s), 1'b0);
            check("lvl_le1", 32'(o_level <= 3'd1), 32'h1);
            if (s == 3) begin
                check("t2_word0", 32'(o_data), 32'h3210);
                check("t2_lanes0", 32'(o_lanes), 32'h4);
            end
            if (s == 7) check("t2_word1", 32'(o_data), 32'h7654);
        end
        drain();

        // 3: fill to full, extra sample refused, then ordered drain
        o_ready = 1'b0;
        for (int s = 0; s < 16; s++) send(4'(s), 1'b0);
        check("t3_full_level", 32'(o_level), 32'h4);
        check("t3_full_ready", 32'(i_ready), 32'h0);
        send(4'h5, 1'b0);
        send(4'h5, 1'b0);
        check("t3_17th_level", 32'(o_level), 32'h4);
        check("t3_17th_head", 32'(o_data), 32'h3210);
        idle();
        o_ready = 1'b1;
        tick();
        check("t3_ready_after_pop", 32'(i_ready), 32'h1);
        check("t3_head1", 32'(o_data), 32'h7654);
        drain();

        // 4: early close with i_last, next word restarts at lane 0
        o_ready = 1'b0;
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        check("t4_last_data", 32'(o_data), 32'h00BA);
        check("t4_last_lanes", 32'(o_lanes), 32'h2);
        for (int s = 12; s < 16; s++) send(4'(s), 1'b0);
        check("t4_next_level", 32'(o_level), 32'h2);
        drain();

        // 5: simultaneous push and pop at occupancy 3
        o_ready = 1'b0;
        for (int s = 0; s < 15; s++) send(4'(s + 1), 1'b0);
        check("t5_level3", 32'(o_level), 32'h3);
        o_ready = 1'b1;
        send(4'h0, 1'b0);
        check("t5_pushpop_level", 32'(o_level), 32'h3);
        drain();

        // 6: reset discards a partial word
        o_ready = 1'b0;
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_rst_level", 32'(o_level), 32'h0);
        check("t6_rst_valid", 32'(o_valid), 32'h0);
        for (int s = 1; s <= 4; s++) send(4'(s), 1'b0);
        check("t6_word", 32'(o_data), 32'h4321);
        check("t6_lanes", 32'(o_lanes), 32'h4);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
